// File: rtl/w_sched_ctrl.sv
// w_sched_ctrl: sequencer for the w64 message-schedule datapath. It issues word indices and
// realigns the delayed cur_w into a (w_valid, w_round, w_word) stream. Optional macro: WSCHED_BLK_COUNT_EN.
module w_sched_ctrl #(
    parameter int W_LENGTH = 64,
    parameter int PIPE_LAT = 3,
    localparam int IDX_W = $clog2(W_LENGTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    output logic [511:0]     msg_vector,
    output logic             w_en,
    output logic [IDX_W-1:0] w_idx,
    output logic             w_idx_done,
    input  logic [31:0]      cur_w,
    output logic             w_valid,
    output logic [IDX_W-1:0] w_round,
    output logic [31:0]      w_word,
    output logic             block_done,
    output logic             busy,
    output logic [15:0]      blk_count
);
    localparam int CNT_W = $clog2(PIPE_LAT + 2);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(W_LENGTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(PIPE_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, GAP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             issue;
    logic             vld_p [PIPE_LAT];
    logic [IDX_W-1:0] idx_p [PIPE_LAT];

    assign accept = blk_valid && blk_ready;
    assign w_idx  = idx_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // DRAIN covers the datapath latency; GAP lets its delayed complete flag and w_vector clear.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        blk_ready  = 1'b0;
        busy       = 1'b1;
        w_en       = 1'b0;
        w_idx_done = 1'b0;
        issue      = 1'b0;
        unique case (state_q)
            IDLE: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
            end
            ISSUE: begin
                w_en  = 1'b1;
                issue = 1'b1;
            end
            DRAIN: begin
                w_en       = 1'b1;
                w_idx_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            msg_vector <= '0;
        end else if (accept) begin
            msg_vector <= blk_data;
        end
    end

    // Delay line p0..p(PIPE_LAT-1): an index issued in cycle t emerges in cycle t+PIPE_LAT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                vld_p[i] <= 1'b0;
                idx_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= issue;
            idx_p[0] <= idx_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                idx_p[i] <= idx_p[i-1];
            end
        end
    end

    assign w_valid    = vld_p[PIPE_LAT-1];
    assign w_round    = idx_p[PIPE_LAT-1];
    assign w_word     = cur_w;
    assign block_done = w_valid && (w_round == LAST_IDX);

`ifdef WSCHED_BLK_COUNT_EN
    logic [15:0] blk_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blk_count_q <= 16'h0000;
        end else if (block_done) begin
            blk_count_q <= blk_count_q + 16'h0001;
        end
    end

    assign blk_count = blk_count_q;
`else
    assign blk_count = 16'h0000;
`endif

endmodule

// File: tb/tb_w_sched_ctrl.sv
// Bench for w_sched_ctrl: emulates the w64 datapath and scoreboards the round stream
// against a SHA-256 message-schedule model computed from the blocks the bench offers.
module tb_w_sched_ctrl;
    localparam int W_LENGTH = 64;
    localparam int PIPE_LAT = 3;
`ifdef WSCHED_BLK_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic [511:0] msg_vector;
    logic         w_en;
    logic [5:0]   w_idx;
    logic         w_idx_done;
    logic [31:0]  cur_w;
    logic         w_valid;
    logic [5:0]   w_round;
    logic [31:0]  w_word;
    logic         block_done;
    logic         busy;
    logic [15:0]  blk_count;

    w_sched_ctrl #(.W_LENGTH(W_LENGTH), .PIPE_LAT(PIPE_LAT)) dut (
        .clock(clock), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .msg_vector(msg_vector), .w_en(w_en), .w_idx(w_idx),
        .w_idx_done(w_idx_done), .cur_w(cur_w), .w_valid(w_valid), .w_round(w_round),
        .w_word(w_word), .block_done(block_done), .busy(busy), .blk_count(blk_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sched_word(input logic [511:0] m, input int r);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        return w[r];
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Emulated w64 datapath: the word for the index presented with w_en appears PIPE_LAT cycles later.
    logic       dp_v [PIPE_LAT];
    logic [5:0] dp_i [PIPE_LAT];
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dp_v[i] <= 1'b0;
                dp_i[i] <= '0;
            end
        end else begin
            dp_v[0] <= w_en;
            dp_i[0] <= w_idx;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dp_v[i] <= dp_v[i-1];
                dp_i[i] <= dp_i[i-1];
            end
        end
    end
    always_comb begin
        cur_w = 32'h0;
        if (dp_v[PIPE_LAT-1]) cur_w = sched_word(msg_vector, int'(dp_i[PIPE_LAT-1]));
    end

    typedef struct {
        int          cyc;
        int          blk;
        int          rnd;
        logic [31:0] w;
    } exp_t;

    exp_t         exp_q [$];
    int           cyc = 0;
    int           free_cyc = 0;
    int           acc_cnt = 0;
    int           exp_blocks = 0;
    logic [511:0] model_msg = '0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a block offered while the controller is free is taken; its 64 words
    // follow 1+PIPE_LAT cycles later and the controller is free again W_LENGTH+2*PIPE_LAT+2 cycles on.
    initial forever begin
        @(posedge clock);
        if (!reset && blk_valid && cyc >= free_cyc) begin
            model_msg = blk_data;
            for (int r = 0; r < W_LENGTH; r++)
                exp_q.push_back('{cyc: cyc + 1 + PIPE_LAT + r, blk: acc_cnt, rnd: r,
                                  w: sched_word(blk_data, r)});
            free_cyc = cyc + W_LENGTH + 2*PIPE_LAT + 2;
            acc_cnt++;
        end
        cyc++;
    end

    initial forever begin
        exp_t e;
        bit   exp_v;
        @(negedge clock);
        if (!reset) begin
            chk("blk_ready", blk_ready, cyc >= free_cyc);
            chk("busy", busy, cyc < free_cyc);
            chk("msg_vector", msg_vector, model_msg);
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("w_valid", w_valid, exp_v);
            if (exp_v) begin
                e = exp_q.pop_front();
                chk("w_round", w_round, e.rnd);
                chk("w_word", w_word, e.w);
                chk("block_done", block_done, e.rnd == W_LENGTH - 1);
                if (e.blk == 0) begin
                    if (e.rnd == 0)  chk("abc_w0",  w_word, 32'h61626380);
                    if (e.rnd == 15) chk("abc_w15", w_word, 32'h00000018);
                    if (e.rnd == 16) chk("abc_w16", w_word, 32'h61626380);
                    if (e.rnd == 17) chk("abc_w17", w_word, 32'h000F0000);
                end
                if (e.rnd == W_LENGTH - 1) exp_blocks++;
            end else begin
                chk("block_done_quiet", block_done, 1'b0);
            end
        end
    end

    task automatic wait_accept(input int target);
        int n = 0;
        while (acc_cnt < target && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        if (acc_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: accepted %0d required %0d", acc_cnt, target);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(blk_ready && cyc >= free_cyc && exp_q.size() == 0) && n < 1000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("idle_ready", blk_ready, 1'b1);
    endtask

    task automatic send_block(input logic [511:0] d);
        blk_data  = d;
        blk_valid = 1'b1;
        wait_accept(acc_cnt + 1);
        blk_valid = 1'b0;
    endtask

    initial begin
        int           n;
        int           acc_c;
        logic [511:0] abc;
        abc       = {32'h61626380, 448'h0, 32'h00000018};
        reset     = 1'b1;
        blk_valid = 1'b0;
        blk_data  = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_blk_ready", blk_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_w_en", w_en, 1'b0);
        chk("rst_w_idx", w_idx, 6'd0);
        chk("rst_w_idx_done", w_idx_done, 1'b0);
        chk("rst_w_valid", w_valid, 1'b0);
        chk("rst_block_done", block_done, 1'b0);
        chk("rst_msg_vector", msg_vector, 512'h0);
        chk("rst_blk_count", blk_count, 16'h0);
        #2 reset = 1'b0;
        @(posedge clock); #1;

        // "abc" block with exact timing of done and return to idle
        blk_data  = abc;
        blk_valid = 1'b1;
        acc_c     = cyc;
        wait_accept(1);
        blk_valid = 1'b0;
        chk("issue_w_en", w_en, 1'b1);
        chk("issue_first_idx", w_idx, 6'd0);
        n = 0;
        while (!block_done && n < 200) begin @(negedge clock); n++; end
        chk("done_offset", cyc - acc_c, 67);
        n = 0;
        while (!blk_ready && n < 200) begin @(negedge clock); n++; end
        chk("idle_offset", cyc - acc_c, 72);
        chk("idle_busy", busy, 1'b0);
        @(posedge clock); #1;

        // valid held high across two blocks
        blk_data  = rand_block();
        blk_valid = 1'b1;
        n = acc_cnt;
        wait_accept(n + 1);
        blk_data = rand_block();
        wait_accept(n + 2);
        blk_valid = 1'b0;
        wait_idle();

        // valid toggled with other data while busy must be ignored
        send_block(rand_block());
        for (int i = 0; i < 40; i++) begin
            blk_valid = 1'($urandom_range(0, 1));
            blk_data  = rand_block();
            @(posedge clock); #1;
        end
        blk_valid = 1'b0;
        wait_idle();

        // reset in the middle of a block
        send_block(rand_block());
        n = 0;
        while (!(w_valid && w_round == 6'd30) && n < 200) begin @(negedge clock); n++; end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL round30_timeout: waited %0d cycles required <200", n);
        end
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_w_valid", w_valid, 1'b0);
        chk("mid_rst_block_done", block_done, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_blk_ready", blk_ready, 1'b1);
        chk("mid_rst_w_en", w_en, 1'b0);
        chk("mid_rst_w_idx", w_idx, 6'd0);
        chk("mid_rst_w_idx_done", w_idx_done, 1'b0);
        chk("mid_rst_w_round", w_round, 6'd0);
        chk("mid_rst_msg_vector", msg_vector, 512'h0);
        chk("mid_rst_blk_count", blk_count, 16'h0);
        exp_q.delete();
        free_cyc   = 0;
        model_msg  = '0;
        exp_blocks = 0;
        #1 reset = 1'b0;
        @(posedge clock); #1;
        send_block(rand_block());
        wait_idle();

        // random blocks with random idle gaps
        for (int k = 0; k < 5; k++) begin
            send_block(rand_block());
            repeat ($urandom_range(0, 8)) @(posedge clock);
            #1;
        end
        wait_idle();
        chk("blk_count", blk_count, CNT_EN ? 16'(exp_blocks) : 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
